// File: rtl/mux_n_stream.sv
// mux_n_stream: N-channel W-bit stream mux with registered output, fixed-select or round-robin grant.
// Define MUX_N_XFER_CNT_EN to add the 32-bit accepted-word counter port xfer_cnt.
module mux_n_stream #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int SW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_ch
`ifdef MUX_N_XFER_CNT_EN
    ,
    output logic [31:0]    xfer_cnt
`endif
);
    logic [SW-1:0] ptr, rr_gnt, gnt;
    logic [SW:0]   idx;
    logic          free, gnt_ok, sel_ok, load;
    // scan from ptr+N-1 down to ptr so the last hit is the first valid channel at or after ptr
    always_comb begin
        rr_gnt = ptr;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SW+1)'(k);
            if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
            if (in_valid[idx[SW-1:0]]) rr_gnt = idx[SW-1:0];
        end
    end
    always_comb begin
        sel_ok = {1'b0, sel} < (SW+1)'(N);
        gnt    = mode ? rr_gnt : sel;
        gnt_ok = mode ? |in_valid : sel_ok && in_valid[sel];
        free   = !out_valid || out_ready;
        load   = rst_n && free && gnt_ok;
        in_ready = load ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (free) begin
            out_valid <= gnt_ok;
            if (gnt_ok) begin
                out_data <= in_data[gnt*W +: W];
                out_ch   <= gnt;
                if (mode) ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end
`ifdef MUX_N_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt <= '0;
        else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 32'd1;
    end
`endif
endmodule
